decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RV32I instruction decode stage, sitting directly upstream of the register file and downstream of fetch.
- Accepts one instruction per valid/ready handshake and drives the register file read ports combinationally.
- Decodes fields, generates the immediate and control signals, and captures everything (including register read data) into the ID/EX pipeline register for execute.

Parameters:
XLEN, 32, datapath / PC / immediate width
ADDR_SIZE, 5, register address width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
flush  input  1  squash output register and block input this cycle
in_valid  input  1  fetch presents instruction
in_ready  output  1  stage can accept
in_instr  input  32  instruction word
in_pc  input  XLEN  instruction PC
rf_read_enable1  output  1  rs1 read enable
rf_read_enable2  output  1  rs2 read enable
rf_read_addr1  output  ADDR_SIZE  rs1 index
rf_read_addr2  output  ADDR_SIZE  rs2 index
rf_read_data1  input  XLEN  rs1 data (same-cycle)
rf_read_data2  input  XLEN  rs2 data (same-cycle)
out_valid  output  1  ID/EX entry valid
out_ready  input  1  execute accepts entry
out_pc  output  XLEN  PC
out_rs1_data  output  XLEN  captured rs1 data
out_rs2_data  output  XLEN  captured rs2 data
out_imm  output  XLEN  sign-extended immediate
out_rd  output  ADDR_SIZE  destination index
out_rd_we  output  1  writeback enable
out_alu_op  output  5  ALU operation
out_src_b_imm  output  1  ALU B operand = imm
out_mem_read  output  1  load
out_mem_write  output  1  store
out_mem_size  output  3  funct3 of load/store
out_branch  output  1  conditional branch (funct3 in out_mem_size)
out_jump  output  1  JAL/JALR
out_illegal  output  1  illegal encoding

Behaviour:
- Reset (rst=0, async): every output register is 0; out_valid=0.
- in_ready = !flush && (!out_valid || out_ready). Transfer = in_valid && in_ready.
- Read ports are combinational from in_instr:
  - rf_read_addr1 = instr[19:15]; rf_read_addr2 = instr[24:20].
  - rf_read_enable1 = transfer && the opcode uses rs1 (not LUI/AUIPC/JAL).
  - rf_read_enable2 = transfer && opcode is R-type, store or branch.
  - When not transferring, both enables are 0.
- On transfer, at the next clk edge: all decoded fields plus rf_read_data1/2 are registered and out_valid=1. Latency is 1 cycle.
- If out_valid && !out_ready && !flush: all outputs hold stable.
- If out_ready && !transfer: out_valid <= 0.
- flush has priority: out_valid <= 0 next edge and no capture that cycle. Payload registers may keep stale values.
- Immediates (I/S/B/U/J) follow the standard RV32I formats. B/J imm[0]=0. U-type is imm<<12. Sign-extended to XLEN. R-type imm = 0.
- alu_op encoding:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10 (LUI).
  - Loads, stores, AUIPC, JAL and JALR use ADD.
  - Branches use SUB.
- out_rd_we = 1 for R, I-ALU, load, LUI, AUIPC, JAL, JALR, and only when rd != 0.
- Illegal: instr[1:0] != 2'b11, unknown opcode, or bad funct7 (R-type, and SLLI/SRLI/SRAI).
  - An illegal entry still transfers with out_illegal=1.
  - For an illegal entry, out_rd_we, out_mem_read, out_mem_write, out_branch and out_jump are all 0.
- FENCE/SYSTEM decode to a NOP: legal, no writeback.
- Reset asserted mid-stall discards the held entry; in_ready is 1 after reset release.

Optional Feature:
- Macro: DECODE_M_EXT_EN.
- Defined: OP with funct7=7'b0000001 decodes as RV32M. out_alu_op = 16 + funct3 (MUL=16 … REMU=23), rd_we per the rd rule, both read enables asserted.
- Undefined: that encoding is illegal (out_illegal=1), and alu_op codes 16-23 are never produced.

Test Plan:
- ADDI x5,x1,-3 (0xFFD08293), out_ready=1:
  - Same cycle: rf_read_enable1=1, rf_read_addr1=1, rf_read_enable2=0.
  - Next cycle: out_valid=1, out_rd=5, out_rd_we=1, out_imm=0xFFFFFFFD, out_alu_op=0, out_src_b_imm=1, out_rs1_data equals rf_read_data1.
- SW x2,8(x3) (0x0021A423): rf_read_addr1=3, rf_read_addr2=2, both enables 1 → out_mem_write=1, out_mem_size=2, out_imm=8, out_rd_we=0.
- MUL x1,x2,x3 (0x023100B3):
  - With DECODE_M_EXT_EN: out_alu_op=16, out_rd_we=1, out_illegal=0.
  - Without it: out_illegal=1, out_rd_we=0.
- Backpressure: entry valid, out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, read enables 0, outputs unchanged; out_ready=1 → next instruction captured the following cycle.
- Flush: in_valid=1 and flush=1 together → in_ready=0, out_valid=0 next cycle, no capture.
- Async reset: drop rst mid-stall between clock edges → out_valid=0 immediately; after release, ADDI x0,x0,0 gives out_rd_we=0, out_valid=1.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage -- RV32I instruction decode stage with ID/EX pipeline register.
//
// Purpose:
//   Accepts one instruction per in_valid/in_ready handshake from fetch. It
//   drives the register file read ports combinationally from the incoming
//   instruction, decodes the instruction, and generates the immediate and
//   the control signals. On a transfer, it captures the decoded fields and
//   the same-cycle register read data into the ID/EX register.
//
// Optional feature (macro DECODE_M_EXT_EN):
//   When the macro is defined, OP with funct7=0000001 decodes as RV32M and
//   out_alu_op = 16 + funct3. When it is undefined, that encoding is illegal.
//
// Ports:
//   clk, rst (async, active-low), flush (squash ID/EX, block input)
//   in_valid/in_ready/in_instr/in_pc            : fetch side handshake
//   rf_read_enable1/2, rf_read_addr1/2          : register file read request
//   rf_read_data1/2                             : same-cycle read data
//   out_valid/out_ready                         : execute side handshake
//   out_pc, out_rs1_data, out_rs2_data, out_imm : captured datapath values
//   out_rd, out_rd_we, out_alu_op, out_src_b_imm, out_mem_read,
//   out_mem_write, out_mem_size, out_branch, out_jump, out_illegal
//                                               : captured control
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 rf_read_enable1,
  output logic                 rf_read_enable2,
  output logic [ADDR_SIZE-1:0] rf_read_addr1,
  output logic [ADDR_SIZE-1:0] rf_read_addr2,
  input  logic [XLEN-1:0]      rf_read_data1,
  input  logic [XLEN-1:0]      rf_read_data2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_rs1_data,
  output logic [XLEN-1:0]      out_rs2_data,
  output logic [XLEN-1:0]      out_imm,
  output logic [ADDR_SIZE-1:0] out_rd,
  output logic                 out_rd_we,
  output logic [4:0]           out_alu_op,
  output logic                 out_src_b_imm,
  output logic                 out_mem_read,
  output logic                 out_mem_write,
  output logic [2:0]           out_mem_size,
  output logic                 out_branch,
  output logic                 out_jump,
  output logic                 out_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_PASSB = 5'd10;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_field;
  logic       transfer;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rd_field = in_instr[11:7];

  assign in_ready = !flush && (!out_valid || out_ready);
  assign transfer = in_valid && in_ready;

  // Base ALU mapping shared by OP and OP-IMM; alt selects SUB/SRA.
  function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_base = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_base = ALU_SLL;
      3'b010:  alu_base = 5'd3;
      3'b011:  alu_base = 5'd4;
      3'b100:  alu_base = 5'd5;
      3'b101:  alu_base = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_base = 5'd8;
      default: alu_base = 5'd9;
    endcase
  endfunction

  logic [31:0] imm32_next;
  logic [4:0]  alu_op_next;
  logic        src_b_imm_next, mem_read_next, mem_write_next;
  logic [2:0]  mem_size_next;
  logic        branch_next, jump_next, writes_rd, illegal_next, rd_we_next;
  logic        uses_rs1, uses_rs2;

  always_comb begin
    imm32_next     = '0;
    alu_op_next    = ALU_ADD;
    src_b_imm_next = 1'b0;
    mem_read_next  = 1'b0;
    mem_write_next = 1'b0;
    mem_size_next  = 3'b000;
    branch_next    = 1'b0;
    jump_next      = 1'b0;
    writes_rd      = 1'b0;
    illegal_next   = 1'b0;
    uses_rs1       = 1'b1;
    uses_rs2       = 1'b0;
    case (opcode)
      OPC_OP: begin
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
        if (funct7 == 7'b0000000)
          alu_op_next = alu_base(funct3, 1'b0);
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          alu_op_next = alu_base(funct3, 1'b1);
`ifdef DECODE_M_EXT_EN
        else if (funct7 == 7'b0000001)
          alu_op_next = {2'b10, funct3};
`endif
        else
          illegal_next = 1'b1;
      end
      OPC_OP_IMM: begin
        writes_rd      = 1'b1;
        src_b_imm_next = 1'b1;
        imm32_next     = {{20{in_instr[31]}}, in_instr[31:20]};
        // Shift-immediates carry funct7 in the upper immediate bits.
        if (funct3 == 3'b001) begin
          alu_op_next = ALU_SLL;
          if (funct7 != 7'b0000000) illegal_next = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0000000)      alu_op_next = ALU_SRL;
          else if (funct7 == 7'b0100000) alu_op_next = ALU_SRA;
          else                           illegal_next = 1'b1;
        end else begin
          alu_op_next = alu_base(funct3, 1'b0);
        end
      end
      OPC_LOAD: begin
        writes_rd      = 1'b1;
        src_b_imm_next = 1'b1;
        mem_read_next  = 1'b1;
        mem_size_next  = funct3;
        imm32_next     = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_STORE: begin
        uses_rs2       = 1'b1;
        src_b_imm_next = 1'b1;
        mem_write_next = 1'b1;
        mem_size_next  = funct3;
        imm32_next     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OPC_BRANCH: begin
        uses_rs2      = 1'b1;
        branch_next   = 1'b1;
        mem_size_next = funct3;
        alu_op_next   = ALU_SUB;
        imm32_next    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OPC_LUI: begin
        uses_rs1       = 1'b0;
        writes_rd      = 1'b1;
        src_b_imm_next = 1'b1;
        alu_op_next    = ALU_PASSB;
        imm32_next     = {in_instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        uses_rs1       = 1'b0;
        writes_rd      = 1'b1;
        src_b_imm_next = 1'b1;
        imm32_next     = {in_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        uses_rs1       = 1'b0;
        writes_rd      = 1'b1;
        jump_next      = 1'b1;
        src_b_imm_next = 1'b1;
        imm32_next     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        writes_rd      = 1'b1;
        jump_next      = 1'b1;
        src_b_imm_next = 1'b1;
        imm32_next     = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_FENCE, OPC_SYSTEM: ; // treated as NOP: legal, no side effects
      default: illegal_next = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) illegal_next = 1'b1;
    // Illegal entries flow down the pipe but must not cause side effects.
    if (illegal_next) begin
      writes_rd      = 1'b0;
      mem_read_next  = 1'b0;
      mem_write_next = 1'b0;
      branch_next    = 1'b0;
      jump_next      = 1'b0;
    end
    rd_we_next = writes_rd && (rd_field != 5'd0);
  end

  assign rf_read_addr1   = ADDR_SIZE'(in_instr[19:15]);
  assign rf_read_addr2   = ADDR_SIZE'(in_instr[24:20]);
  assign rf_read_enable1 = transfer && uses_rs1;
  assign rf_read_enable2 = transfer && uses_rs2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rs1_data  <= '0;
      out_rs2_data  <= '0;
      out_imm       <= '0;
      out_rd        <= '0;
      out_rd_we     <= 1'b0;
      out_alu_op    <= '0;
      out_src_b_imm <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_mem_size  <= '0;
      out_branch    <= 1'b0;
      out_jump      <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_rs1_data  <= rf_read_data1;
      out_rs2_data  <= rf_read_data2;
      out_imm       <= XLEN'($signed(imm32_next));
      out_rd        <= ADDR_SIZE'(rd_field);
      out_rd_we     <= rd_we_next;
      out_alu_op    <= alu_op_next;
      out_src_b_imm <= src_b_imm_next;
      out_mem_read  <= mem_read_next;
      out_mem_write <= mem_write_next;
      out_mem_size  <= mem_size_next;
      out_branch    <= branch_next;
      out_jump      <= jump_next;
      out_illegal   <= illegal_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage -- directed self-checking bench for decode_stage.
// Each scenario task drives stimulus and compares outputs against
// hand-computed values; a single summary line is printed at the end.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        rf_read_enable1, rf_read_enable2;
  logic [4:0]  rf_read_addr1, rf_read_addr2;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [4:0]  out_alu_op;
  logic        out_src_b_imm, out_mem_read, out_mem_write;
  logic [2:0]  out_mem_size;
  logic        out_branch, out_jump, out_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .ADDR_SIZE(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_read_enable1(rf_read_enable1), .rf_read_enable2(rf_read_enable2),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_alu_op(out_alu_op),
    .out_src_b_imm(out_src_b_imm), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_size(out_mem_size),
    .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal)
  );

  task automatic drive(input logic [31:0] i, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2);
    in_valid = 1'b1; in_instr = i; in_pc = pc;
    rf_read_data1 = d1; rf_read_data2 = d2;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    rf_read_data1 = '0; rf_read_data2 = '0; out_ready = 1'b1;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", out_valid); end
    total++; if (out_imm !== 32'h0) begin bad++; $display("FAIL rst_imm got=%h exp=0", out_imm); end
    total++; if (out_rd_we !== 1'b0) begin bad++; $display("FAIL rst_rd_we got=%h exp=0", out_rd_we); end
    #10 rst = 1'b1;
    tick;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%h exp=1", in_ready); end
    $display("reset: in_ready=%h out_valid=%h", in_ready, out_valid);
  endtask

  task automatic test_addi;
    out_ready = 1'b1;
    drive(32'hFFD08293, 32'h0000_1000, 32'hA5A5_0001, 32'h5A5A_0002);
    #1;
    total++; if (rf_read_enable1 !== 1'b1) begin bad++; $display("FAIL addi_en1 got=%h exp=1", rf_read_enable1); end
    total++; if (rf_read_addr1 !== 5'd1) begin bad++; $display("FAIL addi_addr1 got=%h exp=1", rf_read_addr1); end
    total++; if (rf_read_enable2 !== 1'b0) begin bad++; $display("FAIL addi_en2 got=%h exp=0", rf_read_enable2); end
    tick; in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%h exp=1", out_valid); end
    total++; if (out_rd !== 5'd5) begin bad++; $display("FAIL addi_rd got=%h exp=5", out_rd); end
    total++; if (out_rd_we !== 1'b1) begin bad++; $display("FAIL addi_rd_we got=%h exp=1", out_rd_we); end
    total++; if (out_imm !== 32'hFFFFFFFD) begin bad++; $display("FAIL addi_imm got=%h exp=fffffffd", out_imm); end
    total++; if (out_alu_op !== 5'd0) begin bad++; $display("FAIL addi_alu got=%h exp=0", out_alu_op); end
    total++; if (out_src_b_imm !== 1'b1) begin bad++; $display("FAIL addi_srcb got=%h exp=1", out_src_b_imm); end
    total++; if (out_rs1_data !== 32'hA5A5_0001) begin bad++; $display("FAIL addi_rs1 got=%h exp=a5a50001", out_rs1_data); end
    total++; if (out_pc !== 32'h0000_1000) begin bad++; $display("FAIL addi_pc got=%h exp=00001000", out_pc); end
    $display("addi: rd=%0d imm=%h alu=%0d", out_rd, out_imm, out_alu_op);
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%h exp=0", out_valid); end
  endtask

  task automatic test_store;
    drive(32'h0021A423, 32'h0000_1004, 32'h0000_0100, 32'hDEAD_BEEF);
    #1;
    total++; if (rf_read_addr1 !== 5'd3) begin bad++; $display("FAIL sw_addr1 got=%h exp=3", rf_read_addr1); end
    total++; if (rf_read_addr2 !== 5'd2) begin bad++; $display("FAIL sw_addr2 got=%h exp=2", rf_read_addr2); end
    total++; if ({rf_read_enable1, rf_read_enable2} !== 2'b11) begin bad++; $display("FAIL sw_en got=%b exp=11", {rf_read_enable1, rf_read_enable2}); end
    tick; in_valid = 1'b0;
    total++; if (out_mem_write !== 1'b1) begin bad++; $display("FAIL sw_mem_write got=%h exp=1", out_mem_write); end
    total++; if (out_mem_size !== 3'd2) begin bad++; $display("FAIL sw_size got=%h exp=2", out_mem_size); end
    total++; if (out_imm !== 32'd8) begin bad++; $display("FAIL sw_imm got=%h exp=8", out_imm); end
    total++; if (out_rd_we !== 1'b0) begin bad++; $display("FAIL sw_rd_we got=%h exp=0", out_rd_we); end
    total++; if (out_rs2_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_rs2 got=%h exp=deadbeef", out_rs2_data); end
    $display("sw: size=%0d imm=%h", out_mem_size, out_imm);
  endtask

  task automatic test_branch_lui_jal;
    // beq x1,x2,-8
    drive(32'hFE208CE3, 32'h0000_2000, 32'h1, 32'h2);
    tick;
    total++; if (out_imm !== 32'hFFFFFFF8) begin bad++; $display("FAIL beq_imm got=%h exp=fffffff8", out_imm); end
    total++; if (out_alu_op !== 5'd1) begin bad++; $display("FAIL beq_alu got=%h exp=1", out_alu_op); end
    total++; if ({out_branch, out_rd_we, out_src_b_imm} !== 3'b100) begin bad++; $display("FAIL beq_ctl got=%b exp=100", {out_branch, out_rd_we, out_src_b_imm}); end
    $display("beq: imm=%h alu=%0d", out_imm, out_alu_op);
    // lui x7,0x12345
    drive(32'h123453B7, 32'h0000_2004, 32'h0, 32'h0);
    #1;
    total++; if (rf_read_enable1 !== 1'b0) begin bad++; $display("FAIL lui_en1 got=%h exp=0", rf_read_enable1); end
    tick;
    total++; if (out_imm !== 32'h12345000) begin bad++; $display("FAIL lui_imm got=%h exp=12345000", out_imm); end
    total++; if (out_alu_op !== 5'd10) begin bad++; $display("FAIL lui_alu got=%h exp=a", out_alu_op); end
    total++; if (out_rd_we !== 1'b1) begin bad++; $display("FAIL lui_rd_we got=%h exp=1", out_rd_we); end
    $display("lui: imm=%h alu=%0d", out_imm, out_alu_op);
    // jal x1,16
    drive(32'h010000EF, 32'h0000_2008, 32'h0, 32'h0);
    tick; in_valid = 1'b0;
    total++; if (out_imm !== 32'd16) begin bad++; $display("FAIL jal_imm got=%h exp=10", out_imm); end
    total++; if ({out_jump, out_rd_we, out_branch} !== 3'b110) begin bad++; $display("FAIL jal_ctl got=%b exp=110", {out_jump, out_rd_we, out_branch}); end
    $display("jal: imm=%h jump=%h", out_imm, out_jump);
  endtask

  task automatic test_illegal;
    drive(32'h0000_0000, 32'h3000, 32'h0, 32'h0);  // low bits != 11
    tick;
    total++; if (out_illegal !== 1'b1) begin bad++; $display("FAIL zero_illegal got=%h exp=1", out_illegal); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL zero_valid got=%h exp=1", out_valid); end
    $display("zero word: illegal=%h", out_illegal);
    drive(32'h40109093, 32'h3004, 32'h0, 32'h0);  // slli with funct7=0100000
    tick;
    total++; if ({out_illegal, out_rd_we} !== 2'b10) begin bad++; $display("FAIL slli_bad got=%b exp=10", {out_illegal, out_rd_we}); end
    $display("bad slli: illegal=%h rd_we=%h", out_illegal, out_rd_we);
    drive(32'h4030D113, 32'h3008, 32'h0, 32'h0);  // srai x2,x1,3
    tick;
    total++; if ({out_illegal, out_alu_op} !== {1'b0, 5'd7}) begin bad++; $display("FAIL srai got=%b/%0d exp=0/7", out_illegal, out_alu_op); end
    $display("srai: alu=%0d", out_alu_op);
    drive(32'h0000028F, 32'h300C, 32'h0, 32'h0);  // fence with rd field=5
    tick;
    total++; if ({out_illegal, out_rd_we} !== 2'b00) begin bad++; $display("FAIL fence got=%b exp=00", {out_illegal, out_rd_we}); end
    $display("fence: illegal=%h rd_we=%h", out_illegal, out_rd_we);
    drive(32'h023100B3, 32'h3010, 32'h0, 32'h0);  // mul x1,x2,x3
    #1;
    total++; if (rf_read_enable2 !== 1'b1) begin bad++; $display("FAIL mul_en2 got=%h exp=1", rf_read_enable2); end
    tick; in_valid = 1'b0;
`ifdef DECODE_M_EXT_EN
    total++; if ({out_illegal, out_rd_we, out_alu_op} !== {1'b0, 1'b1, 5'd16}) begin bad++; $display("FAIL mul_m got=%b/%b/%0d exp=0/1/16", out_illegal, out_rd_we, out_alu_op); end
`else
    total++; if ({out_illegal, out_rd_we} !== 2'b10) begin bad++; $display("FAIL mul_nom got=%b exp=10", {out_illegal, out_rd_we}); end
`endif
    $display("mul: illegal=%h rd_we=%h alu=%0d", out_illegal, out_rd_we, out_alu_op);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b1;
    drive(32'hFFD08293, 32'h4000, 32'h1111_1111, 32'h0);
    tick;
    out_ready = 1'b0;
    drive(32'h0021A423, 32'h4004, 32'h0000_0022, 32'h0000_0033);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if ({in_ready, rf_read_enable1, rf_read_enable2} !== 3'b000) begin bad++; $display("FAIL bp_stall%0d got=%b exp=000", c, {in_ready, rf_read_enable1, rf_read_enable2}); end
      tick;
      total++; if ({out_valid, out_rd, out_rs1_data} !== {1'b1, 5'd5, 32'h1111_1111}) begin bad++; $display("FAIL bp_hold%0d got=%b/%0d/%h exp=1/5/11111111", c, out_valid, out_rd, out_rs1_data); end
      $display("stall %0d: in_ready=%h out_rd=%0d", c, in_ready, out_rd);
    end
    out_ready = 1'b1;
    #1;
    total++; if ({in_ready, rf_read_enable1, rf_read_enable2} !== 3'b111) begin bad++; $display("FAIL bp_release got=%b exp=111", {in_ready, rf_read_enable1, rf_read_enable2}); end
    tick; in_valid = 1'b0;
    total++; if ({out_valid, out_mem_write, out_imm} !== {1'b1, 1'b1, 32'd8}) begin bad++; $display("FAIL bp_next got=%b/%b/%h exp=1/1/8", out_valid, out_mem_write, out_imm); end
    $display("released: mem_write=%h imm=%h", out_mem_write, out_imm);
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    drive(32'h00100493, 32'h5000, 32'h0, 32'h0);  // addi x9,x0,1
    flush = 1'b1;
    #1;
    total++; if ({in_ready, rf_read_enable1} !== 2'b00) begin bad++; $display("FAIL flush_block got=%b exp=00", {in_ready, rf_read_enable1}); end
    tick; flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%h exp=0", out_valid); end
    total++; if (out_rd === 5'd9) begin bad++; $display("FAIL flush_capture got=%0d exp=not 9", out_rd); end
    $display("flush: out_valid=%h", out_valid);
    // flush drops an entry being held under backpressure
    out_ready = 1'b0;
    drive(32'h00100493, 32'h5004, 32'h0, 32'h0);
    tick; in_valid = 1'b0; flush = 1'b1;
    tick; flush = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_held got=%h exp=0", out_valid); end
    $display("flush held: out_valid=%h", out_valid);
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    drive(32'hFFD08293, 32'h6000, 32'h7, 32'h0);
    tick; in_valid = 1'b0; out_ready = 1'b0;
    tick;
    #3 rst = 1'b0;
    #1;
    total++; if ({out_valid, out_rd, in_ready} !== {1'b0, 5'd0, 1'b1}) begin bad++; $display("FAIL arst got=%b/%0d/%b exp=0/0/1", out_valid, out_rd, in_ready); end
    #2 rst = 1'b1;
    tick;
    out_ready = 1'b1;
    drive(32'h00000013, 32'h6004, 32'h0, 32'h0);  // addi x0,x0,0
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%h exp=1", in_ready); end
    tick; in_valid = 1'b0;
    total++; if ({out_valid, out_rd_we, out_illegal} !== 3'b100) begin bad++; $display("FAIL arst_nop got=%b exp=100", {out_valid, out_rd_we, out_illegal}); end
    $display("after reset nop: valid=%h rd_we=%h", out_valid, out_rd_we);
  endtask

  initial begin
    test_reset;
    test_addi;
    test_store;
    test_branch_lui_jal;
    test_illegal;
    test_backpressure;
    test_flush;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
